regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/riscv_pkg.sv | 12 +
 rtl/rf_read_port.sv | 40 ++++
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and the register-file controller state type.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register masking, write forwarding and the
// busy flag for the addressed register.
module rf_read_port #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            i_run,
    input  logic [AW-1:0]   i_ra,
    input  logic [XLEN-1:0] i_entry,
    input  logic            i_pending,
    input  logic            i_wrValid,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd,
    output logic            o_busy
);

    logic w_hit;
    logic w_zero;

    assign w_hit  = (BYPASS != 0) && i_wrValid && (i_ra == i_wa);
    assign w_zero = (ZERO_REG != 0) && (i_ra == '0);

    // A forwarded write means the consumer already has the value, so it is not busy.
    always_comb begin
        o_rd   = '0;
        o_busy = 1'b0;
        if (i_run) begin
            if (w_hit) begin
                o_rd = i_wd;
            end else if (!w_zero) begin
                o_rd = i_entry;
            end
            o_busy = i_pending & ~w_hit & ~w_zero;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-write scoreboard and a post-reset
// sweep that zeroes every entry through the single write port.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREAD*AW-1:0]   RA,
    output logic [NREAD*XLEN-1:0] RD,
    output logic [NREAD-1:0]      RBUSY,
    input  logic [AW-1:0]         WA3,
    input  logic [XLEN-1:0]       WD3,
    input  logic                  WE3,
    input  logic                  SB_SET,
    input  logic [AW-1:0]         SB_A,
    output logic                  READY
);

    rf_state_t       r_state;
    rf_state_t       w_nextState;
    logic [AW-1:0]   r_clearIdx;
    logic [AW-1:0]   w_nextIdx;
    logic [XLEN-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pending;

    logic            w_run;
    logic            w_clearing;
    logic            w_legalWrite;
    logic            w_legalSet;
    logic            w_memWe;
    logic [AW-1:0]   w_memWa;
    logic [XLEN-1:0] w_memWd;

    assign w_run        = (r_state == RUN) && !RST;
    assign w_clearing   = (r_state == CLEAR) && !RST;
    assign w_legalWrite = w_run && WE3 && !((ZERO_REG != 0) && (WA3 == '0));
    assign w_legalSet   = w_run && SB_SET && !((ZERO_REG != 0) && (SB_A == '0));
    assign READY        = w_run;

    // The clear sweep borrows the architectural write port.
    assign w_memWe = w_clearing || w_legalWrite;
    assign w_memWa = (r_state == CLEAR) ? r_clearIdx : WA3;
    assign w_memWd = (r_state == CLEAR) ? '0 : WD3;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= CLEAR;
            r_clearIdx <= '0;
        end else begin
            r_state    <= w_nextState;
            r_clearIdx <= w_nextIdx;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_clearIdx;
        case (r_state)
            CLEAR: begin
                w_nextIdx = r_clearIdx + AW'(1);
                if (r_clearIdx == AW'(DEPTH - 1)) begin
                    w_nextState = RUN;
                end
            end
            default: begin
                w_nextState = r_state;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_memWe) begin
            r_mem[w_memWa] <= w_memWd;
        end
    end

    // A claim issued alongside the retiring write wins: it names a newer producer.
    always_ff @(posedge CLK) begin
        if (w_clearing) begin
            r_pending[r_clearIdx] <= 1'b0;
        end else begin
            if (w_legalWrite) begin
                r_pending[WA3] <= 1'b0;
            end
            if (w_legalSet) begin
                r_pending[SB_A] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_port
        logic [AW-1:0] w_ra;
        assign w_ra = RA[g*AW +: AW];

        rf_read_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .i_run     (w_run),
            .i_ra      (w_ra),
            .i_entry   (r_mem[w_ra]),
            .i_pending (r_pending[w_ra]),
            .i_wrValid (w_legalWrite),
            .i_wa      (WA3),
            .i_wd      (WD3),
            .o_rd      (RD[g*XLEN +: XLEN]),
            .o_busy    (RBUSY[g])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding instance and a non-forwarding instance
// share one stimulus stream and are checked against an array-level model.
module tb_regfile_mp;

    logic        CLK;
    logic        RST;
    logic [9:0]  RA;
    logic [4:0]  WA3;
    logic [31:0] WD3;
    logic        WE3;
    logic        SB_SET;
    logic [4:0]  SB_A;

    logic [63:0] rdA;
    logic [63:0] rdB;
    logic [1:0]  busyA;
    logic [1:0]  busyB;
    logic        readyA;
    logic        readyB;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] mMem [32];
    logic        mPending [32];
    logic        mReady     = 1'b0;
    int          mClearLeft = 32;

    regfile_mp #(.BYPASS(1)) dutA (
        .CLK(CLK), .RST(RST), .RA(RA), .RD(rdA), .RBUSY(busyA),
        .WA3(WA3), .WD3(WD3), .WE3(WE3), .SB_SET(SB_SET), .SB_A(SB_A),
        .READY(readyA)
    );

    regfile_mp #(.BYPASS(0)) dutB (
        .CLK(CLK), .RST(RST), .RA(RA), .RD(rdB), .RBUSY(busyB),
        .WA3(WA3), .WD3(WD3), .WE3(WE3), .SB_SET(SB_SET), .SB_A(SB_A),
        .READY(readyB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected read data from the architectural state plus this cycle's inputs.
    function automatic logic [31:0] expRd(input logic [4:0] ra, input bit byp);
        if (RST || !mReady) return 32'h0;
        if (byp && WE3 && WA3 != 5'd0 && ra == WA3) return WD3;
        if (ra == 5'd0) return 32'h0;
        return mMem[ra];
    endfunction

    function automatic logic expBusy(input logic [4:0] ra, input bit byp);
        if (RST || !mReady || ra == 5'd0) return 1'b0;
        if (byp && WE3 && WA3 != 5'd0 && ra == WA3) return 1'b0;
        return mPending[ra];
    endfunction

    // After reset the block is unavailable for 32 edges, then everything is zero.
    function automatic void modelStep();
        if (RST) begin
            mReady     = 1'b0;
            mClearLeft = 32;
        end else if (!mReady) begin
            mClearLeft--;
            if (mClearLeft == 0) begin
                mReady = 1'b1;
                for (int i = 0; i < 32; i++) begin
                    mMem[i]     = 32'h0;
                    mPending[i] = 1'b0;
                end
            end
        end else begin
            if (WE3 && WA3 != 5'd0) begin
                mMem[WA3]     = WD3;
                mPending[WA3] = 1'b0;
            end
            if (SB_SET && SB_A != 5'd0) mPending[SB_A] = 1'b1;
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        modelStep();
        #1;
    endtask

    task automatic idleInputs();
        RST = 1'b0; WE3 = 1'b0; SB_SET = 1'b0;
        WA3 = 5'd0; WD3 = 32'h0; SB_A = 5'd0; RA = 10'd0;
    endtask

    task automatic test_reset();
        idleInputs();
        RST = 1'b1;
        #1;
        testsRun++;
        if (readyA !== 1'b0 || rdA !== 64'h0 || busyA !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: ready=%b rd=%h busy=%b, required 0/0/0", readyA, rdA, busyA);
        end
        step();
        RST = 1'b0;
        for (int k = 0; k < 32; k++) begin
            WE3 = 1'($urandom_range(0, 1)); WA3 = 5'($urandom_range(1, 31)); WD3 = $urandom;
            SB_SET = 1'($urandom_range(0, 1)); SB_A = 5'($urandom_range(1, 31));
            RA = {WA3, 5'($urandom_range(0, 31))};
            #1;
            testsRun++;
            if (readyA !== 1'b0 || readyB !== 1'b0 || rdA !== 64'h0 || busyA !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL clear_cycle%0d: readyA=%b readyB=%b rd=%h busy=%b, required 0", k, readyA, readyB, rdA, busyA);
            end
            step();
        end
        idleInputs();
        for (int a = 0; a < 32; a++) begin
            RA = {5'(a), 5'(a)};
            #1;
            testsRun++;
            if (readyA !== 1'b1 || readyB !== 1'b1 || rdA !== 64'h0 || rdB !== 64'h0 || busyA !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL after_clear r%0d: ready=%b/%b rdA=%h rdB=%h busy=%b, required 1/1/0/0/0", a, readyA, readyB, rdA, rdB, busyA);
            end
        end
    endtask

    task automatic test_write_read();
        idleInputs();
        WE3 = 1'b1; WA3 = 5'd5; WD3 = 32'hDEADBEEF; RA = {5'd0, 5'd5};
        #1;
        testsRun++;
        if (rdA[31:0] !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL bypass_same_cycle: got %h required deadbeef", rdA[31:0]);
        end
        testsRun++;
        if (rdB[31:0] !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL nobypass_old_value: got %h required 00000000", rdB[31:0]);
        end
        step();
        WE3 = 1'b0;
        #1;
        testsRun++;
        if (rdA[31:0] !== 32'hDEADBEEF || rdB[31:0] !== 32'hDEADBEEF) begin
            testsFailed++;
            $display("[TB] FAIL write_next_cycle: got %h/%h required deadbeef", rdA[31:0], rdB[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        idleInputs();
        WE3 = 1'b1; WA3 = 5'd0; WD3 = 32'h12345678; SB_SET = 1'b1; SB_A = 5'd0; RA = 10'd0;
        #1;
        testsRun++;
        if (rdA !== 64'h0 || rdB !== 64'h0 || busyA !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL x0_same_cycle: rdA=%h rdB=%h busy=%b required 0", rdA, rdB, busyA);
        end
        step();
        WE3 = 1'b0; SB_SET = 1'b0;
        #1;
        testsRun++;
        if (rdA !== 64'h0 || rdB !== 64'h0 || busyA !== 2'b00 || busyB !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL x0_after: rdA=%h rdB=%h busy=%b/%b required 0", rdA, rdB, busyA, busyB);
        end
    endtask

    task automatic test_scoreboard();
        idleInputs();
        SB_SET = 1'b1; SB_A = 5'd7;
        step();
        SB_SET = 1'b0; RA = {5'd7, 5'd0};
        #1;
        testsRun++;
        if (busyA[1] !== 1'b1 || busyB[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sb_pending: got %b/%b required 1/1", busyA[1], busyB[1]);
        end
        WE3 = 1'b1; WA3 = 5'd7; WD3 = 32'h55;
        #1;
        testsRun++;
        if (busyA[1] !== 1'b0 || busyB[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sb_bypass_hit: got %b/%b required 0/1", busyA[1], busyB[1]);
        end
        step();
        WE3 = 1'b0;
        #1;
        testsRun++;
        if (busyA[1] !== 1'b0 || busyB[1] !== 1'b0 || rdA[63:32] !== 32'h55 || rdB[63:32] !== 32'h55) begin
            testsFailed++;
            $display("[TB] FAIL sb_retired: busy=%b/%b rd=%h/%h required 0/0/55/55", busyA[1], busyB[1], rdA[63:32], rdB[63:32]);
        end
    endtask

    task automatic test_collision();
        idleInputs();
        SB_SET = 1'b1; SB_A = 5'd9; WE3 = 1'b1; WA3 = 5'd9; WD3 = 32'hAA; RA = {5'd9, 5'd9};
        step();
        idleInputs();
        RA = {5'd9, 5'd9};
        #1;
        testsRun++;
        if (rdA !== {2{32'hAA}} || rdB !== {2{32'hAA}} || busyA !== 2'b11 || busyB !== 2'b11) begin
            testsFailed++;
            $display("[TB] FAIL collision: rd=%h/%h busy=%b/%b required aa/aa/11/11", rdA, rdB, busyA, busyB);
        end
    endtask

    task automatic test_mid_reset();
        idleInputs();
        WE3 = 1'b1; WA3 = 5'd3; WD3 = 32'h1;
        step();
        idleInputs();
        SB_SET = 1'b1; SB_A = 5'd4;
        step();
        idleInputs();
        RA = {5'd4, 5'd3};
        #1;
        testsRun++;
        if (rdA[31:0] !== 32'h1 || busyA[1] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_setup: rd=%h busy=%b required 1/1", rdA[31:0], busyA[1]);
        end
        RST = 1'b1; WE3 = 1'b1; WA3 = 5'd3; WD3 = 32'hFFFF;
        step();
        RST = 1'b0;
        for (int k = 0; k < 32; k++) begin
            WE3 = 1'b1; WA3 = 5'($urandom_range(1, 31)); WD3 = $urandom | 32'h1;
            SB_SET = 1'b1; SB_A = 5'($urandom_range(1, 31));
            #1;
            testsRun++;
            if (readyA !== 1'b0 || rdA !== 64'h0) begin
                testsFailed++;
                $display("[TB] FAIL midrst_clear%0d: ready=%b rd=%h required 0/0", k, readyA, rdA);
            end
            step();
        end
        idleInputs();
        RA = {5'd4, 5'd3};
        #1;
        testsRun++;
        if (readyA !== 1'b1 || rdA[31:0] !== 32'h0 || busyA[1] !== 1'b0 || rdB[31:0] !== 32'h0 || busyB[1] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_done: ready=%b rd=%h/%h busy=%b/%b required 1/0/0/0/0", readyA, rdA[31:0], rdB[31:0], busyA[1], busyB[1]);
        end
        for (int a = 0; a < 32; a++) begin
            RA = {5'(a), 5'(a)};
            #1;
            testsRun++;
            if (rdA !== 64'h0 || busyA !== 2'b00 || rdB !== 64'h0) begin
                testsFailed++;
                $display("[TB] FAIL midrst_dropped r%0d: rd=%h/%h busy=%b required 0", a, rdA, rdB, busyA);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            RST    = ($urandom_range(0, 149) == 0);
            WE3    = 1'($urandom_range(0, 1));
            WA3    = 5'($urandom_range(0, 7));
            WD3    = $urandom;
            SB_SET = ($urandom_range(0, 3) == 0);
            SB_A   = 5'($urandom_range(0, 7));
            RA     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            testsRun++;
            if (readyA !== (mReady && !RST) || readyB !== (mReady && !RST)) begin
                testsFailed++;
                $display("[TB] FAIL rand_ready c%0d: got %b/%b required %b", c, readyA, readyB, mReady && !RST);
            end
            for (int p = 0; p < 2; p++) begin
                automatic logic [4:0] ra = RA[p*5 +: 5];
                testsRun++;
                if (rdA[p*32 +: 32] !== expRd(ra, 1'b1) || busyA[p] !== expBusy(ra, 1'b1)) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_bypass c%0d p%0d r%0d: rd=%h busy=%b required %h %b", c, p, ra, rdA[p*32 +: 32], busyA[p], expRd(ra, 1'b1), expBusy(ra, 1'b1));
                end
                testsRun++;
                if (rdB[p*32 +: 32] !== expRd(ra, 1'b0) || busyB[p] !== expBusy(ra, 1'b0)) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_nobypass c%0d p%0d r%0d: rd=%h busy=%b required %h %b", c, p, ra, rdB[p*32 +: 32], busyB[p], expRd(ra, 1'b0), expBusy(ra, 1'b0));
                end
            end
            step();
        end
    endtask

    initial begin
        idleInputs();
        #2;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
